// File: rtl/delivery_game_engine.sv
// Multi-lane scrolling delivery game: row generator (LFSR or test rows), lives, score, win/lose FSM.
// One map step every TICK_BASE>>speed PLAY cycles plus STEP/CHECK; no backpressure, outputs registered.
module delivery_game_engine #(
  parameter int          LANES     = 4,
  parameter int          MAP_LEN   = 16,
  parameter int          SCORE_W   = 4,
  parameter int          LIVES     = 3,
  parameter int          WIN_SCORE = 10,
  parameter int          TICK_BASE = 50_000_000,
  parameter int          TICK_W    = 26,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       jogar,
  input  logic [1:0]                 dificuldade,
  input  logic [1:0]                 velocidade,
  input  logic                       velocidade_valida,
  input  logic [LANES-1:0]           botoes,
  input  logic                       modo_teste,
  input  logic [LANES-1:0]           linha_obstaculo,
  input  logic [LANES-1:0]           linha_objetivo,
  output logic [3:0]                 estado,
  output logic [SCORE_W-1:0]         pontuacao,
  output logic [2:0]                 vidas,
  output logic                       pronto,
  output logic                       venceu,
  output logic [2:0]                 db_player_position,
  output logic [LANES*MAP_LEN-1:0]   db_map_obstacle,
  output logic [LANES*MAP_LEN-1:0]   db_map_objective
);

  localparam int NB = LANES * MAP_LEN;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT  = 4'd1,
    S_PLAY  = 4'd2,
    S_STEP  = 4'd3,
    S_CHECK = 4'd4,
    S_OVER  = 4'd5,
    S_WIN   = 4'd6
  } state_t;

  state_t              state_q, state_d;
  logic [NB-1:0]       obs_q, obs_d;
  logic [NB-1:0]       obj_q, obj_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [2:0]          lives_q, lives_d;
  logic [2:0]          lane_q, lane_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [1:0]          vel_q, vel_d;
  logic [TICK_W-1:0]   tick_q, tick_d;

  logic [2:0]          spd_sum;
  logic [1:0]          spd_lvl;
  logic [TICK_W-1:0]   period_m1;
  logic [LANES-1:0]    raw_obs, new_obs, new_obj;
  logic                lfsr_fb;
  logic [2:0]          btn_idx;
  logic [NB-1:0]       row0_mask;
  logic                hit_obs, hit_obj;
  logic [SCORE_W-1:0]  score_inc;

  // Step period; the >= compare lets a speed-up take effect even when the counter is already past it.
  always_comb begin
    spd_sum   = {1'b0, dificuldade} + {1'b0, vel_q};
    spd_lvl   = (spd_sum > 3'd3) ? 2'd3 : spd_sum[1:0];
    period_m1 = TICK_W'((TICK_BASE >> spd_lvl) - 1);
  end

  always_comb begin
    raw_obs = modo_teste ? linha_obstaculo : (lfsr_q[LANES-1:0] & lfsr_q[LANES+7:8]);
    new_obs = raw_obs;
    if (&raw_obs) new_obs[0] = 1'b0;
    if (modo_teste) new_obj = linha_objetivo & ~new_obs;
    else new_obj = ~raw_obs & (lfsr_q[LANES-1:0] ^ lfsr_q[LANES+7:8]) & {LANES{lfsr_q[15]}};
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  always_comb begin
    btn_idx = 3'd0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (botoes[l]) btn_idx = 3'(l);
    end
  end

  // Row-0 cell of the player's lane, as a mask over the flattened map.
  always_comb begin
    row0_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      row0_mask[l*MAP_LEN] = (lane_q == 3'(l));
    end
    hit_obs   = |(obs_q & row0_mask);
    hit_obj   = |(obj_q & row0_mask);
    score_inc = score_q + SCORE_W'(1);
  end

  always_comb begin
    state_d = state_q;
    obs_d   = obs_q;
    obj_d   = obj_q;
    score_d = score_q;
    lives_d = lives_q;
    lane_d  = lane_q;
    lfsr_d  = lfsr_q;
    tick_d  = tick_q;
    vel_d   = velocidade_valida ? velocidade : vel_q;
    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (jogar) state_d = S_INIT;
      end
      S_INIT: begin
        obs_d   = '0;
        obj_d   = '0;
        tick_d  = '0;
        score_d = '0;
        lives_d = 3'(LIVES);
        lane_d  = 3'd0;
        lfsr_d  = SEED;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (|botoes) lane_d = btn_idx;
        if (tick_q >= period_m1) begin
          tick_d  = '0;
          state_d = S_STEP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_STEP: begin
        for (int l = 0; l < LANES; l++) begin
          for (int r = 0; r < MAP_LEN - 1; r++) begin
            obs_d[l*MAP_LEN+r] = obs_q[l*MAP_LEN+r+1];
            obj_d[l*MAP_LEN+r] = obj_q[l*MAP_LEN+r+1];
          end
          obs_d[l*MAP_LEN+MAP_LEN-1] = new_obs[l];
          obj_d[l*MAP_LEN+MAP_LEN-1] = new_obj[l];
        end
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit_obs) begin
          obs_d   = obs_q & ~row0_mask;
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? S_OVER : S_PLAY;
        end else if (hit_obj) begin
          obj_d   = obj_q & ~row0_mask;
          score_d = score_inc;
          state_d = (score_inc == SCORE_W'(WIN_SCORE)) ? S_WIN : S_PLAY;
        end else begin
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      obs_q   <= '0;
      obj_q   <= '0;
      score_q <= '0;
      lives_q <= 3'd0;
      lane_q  <= 3'd0;
      lfsr_q  <= SEED;
      vel_q   <= 2'd0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      obs_q   <= obs_d;
      obj_q   <= obj_d;
      score_q <= score_d;
      lives_q <= lives_d;
      lane_q  <= lane_d;
      lfsr_q  <= lfsr_d;
      vel_q   <= vel_d;
      tick_q  <= tick_d;
    end
  end

  assign estado             = state_q;
  assign pontuacao          = score_q;
  assign vidas              = lives_q;
  assign pronto             = (state_q == S_OVER) || (state_q == S_WIN);
  assign venceu             = (state_q == S_WIN);
  assign db_player_position = lane_q;
  assign db_map_obstacle    = obs_q;
  assign db_map_objective   = obj_q;

endmodule

// File: tb/tb_delivery_game_engine.sv
// Bench for delivery_game_engine: directed scenarios plus randomized play against a lane/row model.
module tb_delivery_game_engine;
  localparam int          LANES     = 4;
  localparam int          MAP_LEN   = 8;
  localparam int          SCORE_W   = 4;
  localparam int          LIVES     = 3;
  localparam int          WIN_SCORE = 2;
  localparam int          TICK_BASE = 16;
  localparam int          TICK_W    = 5;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          NB        = LANES * MAP_LEN;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              jogar = 1'b0;
  logic [1:0]        dificuldade = 2'd0;
  logic [1:0]        velocidade = 2'd0;
  logic              velocidade_valida = 1'b0;
  logic [LANES-1:0]  botoes = '0;
  logic              modo_teste = 1'b1;
  logic [LANES-1:0]  linha_obstaculo = '0;
  logic [LANES-1:0]  linha_objetivo = '0;
  logic [3:0]        estado;
  logic [SCORE_W-1:0] pontuacao;
  logic [2:0]        vidas;
  logic              pronto, venceu;
  logic [2:0]        db_player_position;
  logic [NB-1:0]     db_map_obstacle, db_map_objective;

  delivery_game_engine #(
    .LANES(LANES), .MAP_LEN(MAP_LEN), .SCORE_W(SCORE_W), .LIVES(LIVES),
    .WIN_SCORE(WIN_SCORE), .TICK_BASE(TICK_BASE), .TICK_W(TICK_W), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
    .velocidade(velocidade), .velocidade_valida(velocidade_valida), .botoes(botoes),
    .modo_teste(modo_teste), .linha_obstaculo(linha_obstaculo), .linha_objetivo(linha_objetivo),
    .estado(estado), .pontuacao(pontuacao), .vidas(vidas), .pronto(pronto), .venceu(venceu),
    .db_player_position(db_player_position), .db_map_obstacle(db_map_obstacle),
    .db_map_objective(db_map_objective)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game phase codes, per-lane row arrays, plain integers.
  int        m_st, m_score, m_lives, m_lane, m_vel, m_cnt;
  bit        m_obs [LANES][MAP_LEN];
  bit        m_obj [LANES][MAP_LEN];
  bit [15:0] m_lfsr;

  task automatic model_clock();
    int nst, per, s;
    bit [LANES-1:0] o, j;
    if (reset) begin
      m_st = 0; m_score = 0; m_lives = 0; m_lane = 0; m_vel = 0; m_cnt = 0; m_lfsr = SEED;
      foreach (m_obs[l, r]) begin m_obs[l][r] = 1'b0; m_obj[l][r] = 1'b0; end
      return;
    end
    nst = m_st;
    s = dificuldade + m_vel;
    if (s > 3) s = 3;
    per = TICK_BASE >> s;
    case (m_st)
      0, 5, 6: if (jogar) nst = 1;
      1: begin
        foreach (m_obs[l, r]) begin m_obs[l][r] = 1'b0; m_obj[l][r] = 1'b0; end
        m_score = 0; m_lives = LIVES; m_lane = 0; m_lfsr = SEED; m_cnt = 0; nst = 2;
      end
      2: begin
        for (int l = 0; l < LANES; l++) if (botoes[l]) begin m_lane = l; break; end
        if (m_cnt >= per - 1) begin m_cnt = 0; nst = 3; end
        else m_cnt++;
      end
      3: begin
        if (modo_teste) begin
          o = linha_obstaculo;
          if (o == '1) o[0] = 1'b0;
          j = linha_objetivo & ~o;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            o[i] = m_lfsr[i] & m_lfsr[i+8];
            j[i] = !o[i] && (m_lfsr[i] != m_lfsr[i+8]) && m_lfsr[15];
          end
          if (o == '1) o[0] = 1'b0;
        end
        for (int l = 0; l < LANES; l++) begin
          for (int r = 0; r < MAP_LEN - 1; r++) begin
            m_obs[l][r] = m_obs[l][r+1];
            m_obj[l][r] = m_obj[l][r+1];
          end
          m_obs[l][MAP_LEN-1] = o[l];
          m_obj[l][MAP_LEN-1] = j[l];
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        nst = 4;
      end
      4: begin
        if (m_obs[m_lane][0]) begin
          m_obs[m_lane][0] = 1'b0; m_lives--; nst = (m_lives == 0) ? 5 : 2;
        end else if (m_obj[m_lane][0]) begin
          m_obj[m_lane][0] = 1'b0; m_score++; nst = (m_score == WIN_SCORE) ? 6 : 2;
        end else nst = 2;
      end
      default: nst = 0;
    endcase
    if (velocidade_valida) m_vel = velocidade;
    m_st = nst;
  endtask

  function automatic logic [NB-1:0] flat(input bit sel_obj);
    logic [NB-1:0] v;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < MAP_LEN; r++)
        v[l*MAP_LEN+r] = sel_obj ? m_obj[l][r] : m_obs[l][r];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic wait_state(input int target, input int budget, output int n);
    n = 0;
    while (estado !== 4'(target) && n < budget) begin tick(); n++; end
  endtask

  task automatic start_game();
    reset = 1'b1; tick(); reset = 1'b0;
    jogar = 1'b1; tick(); jogar = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++; if (estado !== 4'd0) begin n_err++; $display("FAIL reset_estado got %0d want 0", estado); end
    n_vec++; if (pontuacao !== '0 || vidas !== 3'd0) begin n_err++; $display("FAIL reset_counts got score %0d lives %0d want 0 0", pontuacao, vidas); end
    n_vec++; if ({pronto, venceu, db_player_position} !== 5'd0) begin n_err++; $display("FAIL reset_flags got %b want 00000", {pronto, venceu, db_player_position}); end
    n_vec++; if (db_map_obstacle !== '0 || db_map_objective !== '0) begin n_err++; $display("FAIL reset_maps got %h/%h want 0/0", db_map_obstacle, db_map_objective); end
  endtask

  task automatic test_start();
    int n;
    modo_teste = 1'b1; linha_obstaculo = '0; linha_objetivo = '0; botoes = '0; dificuldade = 2'd0;
    reset = 1'b1; tick(); reset = 1'b0;
    jogar = 1'b1; tick(); jogar = 1'b0;
    n_vec++; if (estado !== 4'd1) begin n_err++; $display("FAIL start_init got %0d want 1", estado); end
    tick();
    n_vec++; if (estado !== 4'd2) begin n_err++; $display("FAIL start_play got %0d want 2", estado); end
    n_vec++; if (vidas !== 3'd3 || pontuacao !== '0) begin n_err++; $display("FAIL start_counts got lives %0d score %0d want 3 0", vidas, pontuacao); end
    n_vec++; if (db_map_obstacle !== '0 || db_map_objective !== '0) begin n_err++; $display("FAIL start_maps got %h/%h want 0/0", db_map_obstacle, db_map_objective); end
    wait_state(3, 100, n);
    n_vec++; if (n != 16) begin n_err++; $display("FAIL start_first_step got %0d cycles want 16", n); end
    n_vec++; if (estado !== 4'(m_st)) begin n_err++; $display("FAIL start_model_state got %0d want %0d", estado, m_st); end
  endtask

  task automatic test_hits();
    int n, exp_l;
    modo_teste = 1'b1; linha_obstaculo = 4'b0001; linha_objetivo = '0; botoes = '0; dificuldade = 2'd0;
    start_game();
    for (int k = 1; k <= 10; k++) begin
      wait_state(4, 64, n);
      n_vec++; if (estado !== 4'd4) begin n_err++; $display("FAIL hits_wait step %0d got estado %0d want 4", k, estado); end
      tick();
      exp_l = (k < 8) ? 3 : 10 - k;
      n_vec++; if (vidas !== 3'(exp_l)) begin n_err++; $display("FAIL hits_lives step %0d got %0d want %0d", k, vidas, exp_l); end
    end
    n_vec++; if (estado !== 4'd5 || pronto !== 1'b1 || venceu !== 1'b0) begin n_err++; $display("FAIL hits_over got estado %0d pronto %b venceu %b want 5 1 0", estado, pronto, venceu); end
  endtask

  task automatic test_dodge();
    int n;
    logic [LANES-1:0] top;
    modo_teste = 1'b1; linha_obstaculo = 4'b1111; linha_objetivo = '0; botoes = 4'b0001;
    start_game();
    for (int k = 1; k <= 12; k++) begin
      wait_state(4, 64, n);
      if (k == 1) begin
        for (int l = 0; l < LANES; l++) top[l] = db_map_obstacle[l*MAP_LEN+MAP_LEN-1];
        n_vec++; if (top !== 4'b1110) begin n_err++; $display("FAIL dodge_row got %b want 1110", top); end
      end
      tick();
      n_vec++; if (vidas !== 3'd3) begin n_err++; $display("FAIL dodge_lives step %0d got %0d want 3", k, vidas); end
    end
  endtask

  task automatic test_win();
    int n, exp_s;
    modo_teste = 1'b1; linha_obstaculo = '0; linha_objetivo = 4'b0010; botoes = 4'b0010;
    start_game();
    for (int k = 1; k <= 9; k++) begin
      wait_state(4, 64, n);
      tick();
      exp_s = (k < 8) ? 0 : k - 7;
      n_vec++; if (pontuacao !== SCORE_W'(exp_s)) begin n_err++; $display("FAIL win_score step %0d got %0d want %0d", k, pontuacao, exp_s); end
    end
    n_vec++; if (estado !== 4'd6 || venceu !== 1'b1 || pronto !== 1'b1) begin n_err++; $display("FAIL win_state got estado %0d venceu %b pronto %b want 6 1 1", estado, venceu, pronto); end
    n_vec++; if (db_map_objective[1*MAP_LEN] !== 1'b0 || db_player_position !== 3'd1) begin n_err++; $display("FAIL win_cell got cell %b lane %0d want 0 1", db_map_objective[1*MAP_LEN], db_player_position); end
    botoes = '0; jogar = 1'b1; tick(); jogar = 1'b0;
    n_vec++; if (estado !== 4'd1 || pronto !== 1'b0 || venceu !== 1'b0) begin n_err++; $display("FAIL win_restart got estado %0d pronto %b venceu %b want 1 0 0", estado, pronto, venceu); end
  endtask

  task automatic test_speed();
    int n;
    modo_teste = 1'b1; linha_obstaculo = '0; linha_objetivo = '0; botoes = '0; dificuldade = 2'b01;
    start_game();
    repeat (5) tick();
    velocidade = 2'd2; velocidade_valida = 1'b1; tick(); velocidade_valida = 1'b0;
    n_vec++; if (estado !== 4'd2) begin n_err++; $display("FAIL speed_pre got %0d want 2", estado); end
    tick();
    n_vec++; if (estado !== 4'd3) begin n_err++; $display("FAIL speed_late_step got %0d want 3", estado); end
    n = 0;
    do begin tick(); n++; end while (estado !== 4'd3 && n < 50);
    n_vec++; if (n != 4) begin n_err++; $display("FAIL speed_fast_spacing got %0d want 4", n); end
    velocidade = 2'd0; velocidade_valida = 1'b1; n = 0;
    do begin tick(); velocidade_valida = 1'b0; n++; end while (estado !== 4'd3 && n < 50);
    n_vec++; if (n != 10) begin n_err++; $display("FAIL speed_slow_spacing got %0d want 10", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    modo_teste = 1'b1; linha_obstaculo = 4'b0100; linha_objetivo = 4'b1000; botoes = 4'b0010; dificuldade = 2'b11;
    start_game();
    repeat (20) tick();
    wait_state(2, 16, n);
    n_vec++; if (db_map_obstacle !== flat(0) || db_player_position !== 3'd1) begin n_err++; $display("FAIL midreset_pre got map %h lane %0d want %h 1", db_map_obstacle, db_player_position, flat(0)); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++; if (estado !== 4'd0 || pontuacao !== '0 || vidas !== 3'd0) begin n_err++; $display("FAIL midreset_state got %0d %0d %0d want 0 0 0", estado, pontuacao, vidas); end
    n_vec++; if ({pronto, venceu, db_player_position} !== 5'd0 || db_map_obstacle !== '0 || db_map_objective !== '0) begin n_err++; $display("FAIL midreset_outs got flags %b maps %h/%h want 0", {pronto, venceu, db_player_position}, db_map_obstacle, db_map_objective); end
  endtask

  task automatic test_lfsr();
    logic [NB-1:0] first;
    modo_teste = 1'b0; dificuldade = 2'b11; botoes = '0; linha_obstaculo = '0; linha_objetivo = '0;
    for (int run = 0; run < 2; run++) begin
      start_game();
      repeat (80) tick();
      n_vec++; if (db_map_obstacle !== flat(0)) begin n_err++; $display("FAIL lfsr_obs run %0d got %h want %h", run, db_map_obstacle, flat(0)); end
      n_vec++; if (db_map_objective !== flat(1)) begin n_err++; $display("FAIL lfsr_obj run %0d got %h want %h", run, db_map_objective, flat(1)); end
      if (run == 0) first = flat(0);
      else begin
        n_vec++; if (db_map_obstacle !== first) begin n_err++; $display("FAIL lfsr_repeat got %h want %h", db_map_obstacle, first); end
      end
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        modo_teste = 1'($urandom);
        dificuldade = 2'($urandom);
      end
      reset = ($urandom_range(0, 599) == 0);
      jogar = ($urandom_range(0, 14) == 0);
      botoes = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
      linha_obstaculo = LANES'($urandom) & LANES'($urandom);
      linha_objetivo = LANES'($urandom);
      velocidade = 2'($urandom);
      velocidade_valida = ($urandom_range(0, 29) == 0);
      tick();
      n_vec++; if (estado !== 4'(m_st)) begin n_err++; $display("FAIL rnd_estado cyc %0d got %0d want %0d", c, estado, m_st); end
      n_vec++; if (pontuacao !== SCORE_W'(m_score)) begin n_err++; $display("FAIL rnd_score cyc %0d got %0d want %0d", c, pontuacao, m_score); end
      n_vec++; if (vidas !== 3'(m_lives)) begin n_err++; $display("FAIL rnd_lives cyc %0d got %0d want %0d", c, vidas, m_lives); end
      n_vec++; if (pronto !== (m_st == 5 || m_st == 6) || venceu !== (m_st == 6)) begin n_err++; $display("FAIL rnd_flags cyc %0d got %b%b want state %0d", c, pronto, venceu, m_st); end
      n_vec++; if (db_player_position !== 3'(m_lane)) begin n_err++; $display("FAIL rnd_lane cyc %0d got %0d want %0d", c, db_player_position, m_lane); end
      n_vec++; if (db_map_obstacle !== flat(0)) begin n_err++; $display("FAIL rnd_obs cyc %0d got %h want %h", c, db_map_obstacle, flat(0)); end
      n_vec++; if (db_map_objective !== flat(1)) begin n_err++; $display("FAIL rnd_obj cyc %0d got %h want %h", c, db_map_objective, flat(1)); end
    end
    reset = 1'b0; jogar = 1'b0; velocidade_valida = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_dodge();
    test_win();
    test_speed();
    test_reset_mid();
    test_lfsr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delivery_game_engine.md
# delivery_game_engine

Parametrised single-clock game engine for the next-generation delivery game. It replaces the fixed 7-position, fixed-map datapath/control pair with a configurable multi-lane scrolling map, a lives counter, a win condition and four speed levels. Row generation comes from an internal LFSR or, in test mode, from external row inputs. It sits between the button/ultrasonic front-end (which supplies `velocidade`) and the display/debug outputs.

## Interface
- `LANES`, 4: number of lanes, 2..8.
- `MAP_LEN`, 16: rows per lane, ≥2. Row 0 is the player row.
- `SCORE_W`, 4: width of `pontuacao`.
- `LIVES`, 3: starting lives, 1..7.
- `WIN_SCORE`, 10: score that ends the game with a win, 1..2^SCORE_W−1.
- `TICK_BASE`, 50_000_000: PLAY cycles per step at speed level 0. Must be ≥8.
- `TICK_W`, 26: width of the tick counter. Must hold `TICK_BASE`−1.
- `SEED`, 16'hACE1: LFSR seed, nonzero.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `jogar` in 1: start/restart request (level-sampled).
- `dificuldade` in 2: base speed level.
- `velocidade` in 2: speed bonus from the ultrasonic path. Latched on `velocidade_valida`.
- `velocidade_valida` in 1: one-cycle strobe.
- `botoes` in LANES: lane select. The lowest set bit wins.
- `modo_teste` in 1: 1 = new rows come from `linha_*` instead of the LFSR.
- `linha_obstaculo` in LANES: test-mode obstacle row.
- `linha_objetivo` in LANES: test-mode objective row.
- `estado` out 4: FSM state code.
- `pontuacao` out SCORE_W: score.
- `vidas` out 3: remaining lives.
- `pronto` out 1: 1 in GAME_OVER or WIN.
- `venceu` out 1: 1 in WIN.
- `db_player_position` out 3: current lane index.
- `db_map_obstacle` out LANES*MAP_LEN: bit l*MAP_LEN+r = lane l, row r.
- `db_map_objective` out LANES*MAP_LEN: same layout as `db_map_obstacle`.

## Operation
- States and `estado` codes: IDLE=0, INIT=1, PLAY=2, STEP=3, CHECK=4, GAME_OVER=5, WIN=6.
- Reset values: state IDLE; maps all 0; `pontuacao` 0; `vidas` 0; lane 0; LFSR=`SEED`; latched speed 0; tick counter 0. Consequently `pronto`=0 and `venceu`=0. Reset mid-game aborts immediately to these values.
- IDLE, GAME_OVER, WIN:
  - `jogar`=1 → INIT.
  - Otherwise hold. Score, lives and map stay frozen and visible.
- INIT (1 cycle):
  - Clear both maps and the tick counter.
  - Score=0, lives=`LIVES`, lane=0, LFSR=`SEED`.
  - → PLAY.
- PLAY:
  - If any `botoes` bit is set, lane ← index of the lowest set bit.
  - Tick counter increments. When it equals P−1 → STEP, and the counter clears.
  - `jogar` is ignored.
- Step period: P = `TICK_BASE` >> s, where s = min(`dificuldade` + latched `velocidade`, 3). The sum is computed 3 bits wide.
- `velocidade_valida` latches `velocidade` in every state except reset.
- STEP (1 cycle):
  - Every lane shifts toward row 0: row r ← row r+1. Row `MAP_LEN`−1 ← new row.
  - LFSR advances one step: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
  - → CHECK.
- New row, LFSR mode:
  - obs[i] = q[i] & q[i+8].
  - obj[i] = ~obs[i] & (q[i] ^ q[i+8]) & q[15].
  - q is the LFSR value before advancing.
  - If obs is all ones, bit 0 is cleared, so at least one lane is always free.
- New row, test mode:
  - obs = `linha_obstaculo`, with the same all-ones rule.
  - obj = `linha_objetivo` & ~obs.
- CHECK (1 cycle), inspecting row 0 of the current lane:
  - Obstacle: clear that cell; lives−1. If the new lives value is 0 → GAME_OVER, else → PLAY.
  - Else objective: clear that cell; score+1. If the new score equals `WIN_SCORE` → WIN, else → PLAY.
  - Else → PLAY.
  - Obstacle and objective never coexist in one cell, by construction.
- Collision is evaluated only in CHECK. Moving into row 0 between steps is never a hit.
- Lane changes are ignored outside PLAY.
- Cells shifted out of row 0 are discarded.

## Timing
- `jogar` → INIT next cycle → PLAY the cycle after.
- The first STEP is entered P cycles after PLAY entry.
- STEP-to-STEP spacing is P+2 cycles, since STEP and CHECK are not counted.
- Map outputs reflect the shift one cycle after STEP, i.e. while in CHECK.
- Score and lives update on the CHECK→next-state edge.
- `pronto` and `venceu` assert in the first cycle of GAME_OVER/WIN and hold until INIT.
- A speed change takes effect on the next comparison.
  - If the tick counter is already ≥ the new P−1, STEP occurs on the next cycle.
  - The comparison therefore uses ≥, not ==.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.

## Test plan
Parameters for all scenarios: `LANES`=4, `MAP_LEN`=8, `TICK_BASE`=16, `LIVES`=3, `WIN_SCORE`=2, `modo_teste`=1.

- **Start:** reset, then `jogar` pulse → estado 0→1→2; `vidas`=3, `pontuacao`=0, maps 0; first STEP 16 cycles after PLAY entry.
- **Hits and game over:** `linha_obstaculo`=4'b0001, lane 0, hold → obstacle reaches row 0 on step 8. `vidas`=2 after CHECK, then 1 and 0 on steps 9 and 10. `estado`=5, `pronto`=1.
- **All-ones row, lane dodge:** `linha_obstaculo`=4'b1111 → inserted row is 4'b1110. `botoes`=4'b0001 keeps lane 0 → no hit for all 8+ steps; `vidas` stays 3.
- **Objectives and win:** `linha_objetivo`=4'b0010, `botoes`=4'b0010 → score 1 on step 8, score 2 on step 9 → `estado`=6, `venceu`=1. Cell bit 1*8+0 is cleared.
- **Speed levels:** `dificuldade`=2'b01, `velocidade`=2 strobed → s=3, P=2, STEP spacing 4 cycles. Strobe `velocidade`=0 → spacing 10 cycles.
- **Reset and LFSR reproducibility:** assert `reset` during PLAY → next cycle estado 0, all outputs at reset values. Then in LFSR mode with `modo_teste`=0 and `dificuldade`=2'b11 (P=2), two runs from INIT produce identical `db_map_obstacle` after 20 steps.
